// File: rtl/proc_mon_pkg.sv
// Shared types and defaults for the processor checkpoint monitor.
// Optional per-entry compare mask: define CHK_MASK_EN.
package proc_mon_pkg;

  localparam int unsigned MON_DATA_W     = 64;
  localparam int unsigned MON_NUM_CHECKS = 4;
  localparam int unsigned MON_WDOG_W     = 16;
  localparam int unsigned MON_WDOG_LIMIT = 32'h0000_00FF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_e;

  typedef struct packed {
    logic [MON_DATA_W-1:0] pc;
    logic [MON_DATA_W-1:0] exp;
`ifdef CHK_MASK_EN
    logic [MON_DATA_W-1:0] mask;
`endif
  } mon_entry_t;

  // Requested checkpoint count forced into 1..max_checks.
  function automatic int unsigned clamp_active(input int unsigned n,
                                               input int unsigned max_checks);
    if (n == 0) return 1;
    if (n > max_checks) return max_checks;
    return n;
  endfunction

endpackage

// File: rtl/mon_watchdog.sv
// Saturating run-length watchdog for proc_checkpoint_monitor.
// Unaffected by CHK_MASK_EN.
module mon_watchdog #(
  parameter int unsigned WDOG_W     = 16,
  parameter int unsigned WDOG_LIMIT = 32'h0000_00FF
) (
  input  logic CLK,
  input  logic resetl,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIMIT_C = WDOG_W'(WDOG_LIMIT);

  logic [WDOG_W-1:0] count;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT_C)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT_C);

endmodule

// File: rtl/proc_checkpoint_monitor.sv
// Checkpoint monitor for the single-cycle processor: PC-triggered value checks plus watchdog.
// Define CHK_MASK_EN to add a per-entry compare mask (cfg_mask port).
module proc_checkpoint_monitor
  import proc_mon_pkg::*;
#(
  parameter int unsigned DATA_W     = MON_DATA_W,
  parameter int unsigned NUM_CHECKS = MON_NUM_CHECKS,
  parameter int unsigned IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  parameter int unsigned WDOG_W     = MON_WDOG_W,
  parameter int unsigned WDOG_LIMIT = MON_WDOG_LIMIT
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              start,
  input  logic [IDX_W:0]    num_active,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_pc,
  input  logic [DATA_W-1:0] cfg_exp,
`ifdef CHK_MASK_EN
  input  logic [DATA_W-1:0] cfg_mask,
`endif
  input  logic [DATA_W-1:0] currentpc,
  input  logic [DATA_W-1:0] MemtoRegOut,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              all_passed,
  output logic [IDX_W:0]    pass_count,
  output logic              fail_valid,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [DATA_W-1:0] fail_actual
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_RUN     = ST_RUN;
  localparam logic [1:0] S_DONE    = ST_DONE;
  localparam logic [1:0] S_TIMEOUT = ST_TIMEOUT;

  localparam logic [IDX_W:0] NUM_CHECKS_C = (IDX_W+1)'(NUM_CHECKS);
  localparam logic [IDX_W:0] ONE_C        = (IDX_W+1)'(1);

  logic [1:0]        state;
  mon_entry_t        tbl [NUM_CHECKS];
  logic [IDX_W-1:0]  idx;
  logic [IDX_W:0]    num_lat;

  mon_entry_t        cur;
  logic [DATA_W-1:0] cur_pc;
  logic [DATA_W-1:0] cur_exp;
  logic              hit;
  logic              match;
  logic              last;
  logic [IDX_W:0]    pass_next;
  logic              accept_start;
  logic              tbl_we;
  logic              wd_en;
  logic              wd_expired;

  assign busy         = (state == S_RUN);
  assign accept_start = start && (state != S_RUN);
  assign wd_en        = (state == S_RUN);
  assign tbl_we       = cfg_we && (state != S_RUN) && ({1'b0, cfg_idx} < NUM_CHECKS_C);

  mon_watchdog #(
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .CLK     (CLK),
    .resetl  (resetl),
    .clear   (accept_start),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    cur     = tbl[idx];
    cur_pc  = DATA_W'(cur.pc);
    cur_exp = DATA_W'(cur.exp);
    hit     = (currentpc >= cur_pc);
`ifdef CHK_MASK_EN
    match   = (((MemtoRegOut ^ cur_exp) & DATA_W'(cur.mask)) == '0);
`else
    match   = (MemtoRegOut == cur_exp);
`endif
    last      = (({1'b0, idx} + ONE_C) == num_lat);
    pass_next = pass_count + {{IDX_W{1'b0}}, (hit && match)};
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
        tbl[i] <= '0;
      end
    end else if (tbl_we) begin
      tbl[cfg_idx].pc  <= MON_DATA_W'(cfg_pc);
      tbl[cfg_idx].exp <= MON_DATA_W'(cfg_exp);
`ifdef CHK_MASK_EN
      tbl[cfg_idx].mask <= MON_DATA_W'(cfg_mask);
`endif
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state       <= S_IDLE;
      idx         <= '0;
      num_lat     <= '0;
      pass_count  <= '0;
      fail_valid  <= 1'b0;
      fail_idx    <= '0;
      fail_actual <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      all_passed  <= 1'b0;
    end else if (accept_start) begin
      state       <= S_RUN;
      idx         <= '0;
      num_lat     <= (IDX_W+1)'(clamp_active(32'(num_active), NUM_CHECKS));
      pass_count  <= '0;
      fail_valid  <= 1'b0;
      fail_idx    <= '0;
      fail_actual <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      all_passed  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (hit) begin
            pass_count <= pass_next;
            if (!match && !fail_valid) begin
              fail_valid  <= 1'b1;
              fail_idx    <= idx;
              fail_actual <= MemtoRegOut;
            end
            idx <= idx + 1'b1;
          end
          // Completing the final checkpoint outranks a watchdog hit on the same edge.
          if (hit && last) begin
            state      <= S_DONE;
            done       <= 1'b1;
            all_passed <= (pass_next == num_lat);
          end else if (wd_expired) begin
            state   <= S_TIMEOUT;
            timeout <= 1'b1;
          end
        end
        S_IDLE, S_DONE, S_TIMEOUT: begin
          state <= state;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_checkpoint_monitor.sv
// Self-checking bench for proc_checkpoint_monitor (vectors, corner sequences, random vs model).
// Exercises the cfg_mask path as well when built with CHK_MASK_EN.
module tb_proc_checkpoint_monitor;

  localparam int unsigned DW   = 64;
  localparam int unsigned NC   = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned LIM  = 255;
  localparam int unsigned MAXT = LIM + 1;

  localparam logic [63:0] VAL_A = 64'h0000_0000_0000_000F;
  localparam logic [63:0] VAL_B = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] VAL_C = 64'hCAFE_F00D_0000_0077;

  logic          clk = 1'b0;
  logic          resetl;
  logic          start;
  logic [IW:0]   num_active;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [DW-1:0] cfg_pc;
  logic [DW-1:0] cfg_exp;
`ifdef CHK_MASK_EN
  logic [DW-1:0] cfg_mask;
`endif
  logic [DW-1:0] currentpc;
  logic [DW-1:0] MemtoRegOut;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          all_passed;
  logic [IW:0]   pass_count;
  logic          fail_valid;
  logic [IW-1:0] fail_idx;
  logic [DW-1:0] fail_actual;

  proc_checkpoint_monitor #(
    .DATA_W     (DW),
    .NUM_CHECKS (NC),
    .IDX_W      (IW),
    .WDOG_W     (16),
    .WDOG_LIMIT (LIM)
  ) dut (
    .CLK         (clk),
    .resetl      (resetl),
    .start       (start),
    .num_active  (num_active),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_pc      (cfg_pc),
    .cfg_exp     (cfg_exp),
`ifdef CHK_MASK_EN
    .cfg_mask    (cfg_mask),
`endif
    .currentpc   (currentpc),
    .MemtoRegOut (MemtoRegOut),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .all_passed  (all_passed),
    .pass_count  (pass_count),
    .fail_valid  (fail_valid),
    .fail_idx    (fail_idx),
    .fail_actual (fail_actual)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] data;
    int          exp_pass;
    logic        exp_fv;
    logic        exp_done;
  } vec_t;

  vec_t vecs [2][16];

  logic [63:0] thr [NC];
  logic [63:0] ex  [NC];
  logic [63:0] pcs [1:MAXT];
  logic [63:0] dat [1:MAXT];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int unsigned i, input logic [63:0] p, input logic [63:0] e);
    cfg_we  = 1'b1;
    cfg_idx = IW'(i);
    cfg_pc  = p;
    cfg_exp = e;
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic start_run(input int unsigned na);
    num_active = (IW+1)'(na);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    int unsigned t_to;
    int unsigned na, n_eff, k, mp, mfi, end_t;
    logic        mfv, m_done;
    logic [63:0] mfa, pc;

    // Two-program pass run and the same run with a bad final value.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) begin
        vecs[r][i].pc       = 64'h28 + 64'(4 * i);
        vecs[r][i].data     = (vecs[r][i].pc == 64'h30) ? VAL_A :
                              (vecs[r][i].pc == 64'h60) ? ((r == 0) ? VAL_B : VAL_B + 64'd1) : 64'd0;
        vecs[r][i].exp_done = (vecs[r][i].pc >= 64'h60);
        vecs[r][i].exp_fv   = (r == 1) && vecs[r][i].exp_done;
        vecs[r][i].exp_pass = (vecs[r][i].pc >= 64'h30 ? 1 : 0) +
                              ((r == 0 && vecs[r][i].exp_done) ? 1 : 0);
      end
    end

    resetl = 1'b0; start = 1'b0; num_active = '0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_pc = '0; cfg_exp = '0; currentpc = '0; MemtoRegOut = '0;
`ifdef CHK_MASK_EN
    cfg_mask = '1;
`endif
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_all_passed", all_passed, 0);
    chk("reset_pass_count", pass_count, 0);
    chk("reset_fail_valid", fail_valid, 0);
    chk("reset_fail_actual", fail_actual, 0);
    repeat (2) @(negedge clk);
    resetl = 1'b1;
    tick();

    cfg_write(0, 64'h30, VAL_A);
    cfg_write(1, 64'h60, VAL_B);
    for (int r = 0; r < 2; r++) begin
      start_run(2);
      for (int i = 0; i < 16; i++) begin
        currentpc   = vecs[r][i].pc;
        MemtoRegOut = vecs[r][i].data;
        tick();
        chk($sformatf("vec%0d_%0d_pass", r, i), pass_count, vecs[r][i].exp_pass);
        chk($sformatf("vec%0d_%0d_fv", r, i), fail_valid, vecs[r][i].exp_fv);
        chk($sformatf("vec%0d_%0d_done", r, i), done, vecs[r][i].exp_done);
      end
      chk($sformatf("vec%0d_all_passed", r), all_passed, (r == 0));
      chk($sformatf("vec%0d_timeout", r), timeout, 0);
      if (r == 1) begin
        chk("mismatch_fail_idx", fail_idx, 1);
        chk("mismatch_fail_actual", fail_actual, 64'h1234_5678_9ABC_DEF1);
      end
    end

    // Hang: PC never reaches the first threshold.
    start_run(2);
    currentpc = 64'h10; MemtoRegOut = '0;
    t_to = 0;
    for (int t = 1; t <= 300 && t_to == 0; t++) begin
      tick();
      if (timeout) t_to = t;
    end
    chk("hang_timeout_cycle", t_to, 256);
    chk("hang_done", done, 0);
    chk("hang_busy", busy, 0);

    // Tie: final threshold met on the watchdog's expiry edge.
    cfg_write(0, 64'h1000, 64'd0);
    start_run(1);
    currentpc = '0; MemtoRegOut = '0;
    repeat (LIM) tick();
    chk("tie_busy_before", busy, 1);
    chk("tie_timeout_before", timeout, 0);
    currentpc = 64'h1000;
    tick();
    chk("tie_done", done, 1);
    chk("tie_timeout", timeout, 0);
    chk("tie_pass", pass_count, 1);
    chk("tie_all_passed", all_passed, 1);

    // PC jumps past both thresholds; cfg writes and start during RUN are ignored.
    cfg_write(0, 64'h30, VAL_A);
    cfg_write(1, 64'h60, VAL_B);
    start_run(2);
    currentpc = '0; MemtoRegOut = '0;
    tick();
    chk("jump_pass0", pass_count, 0);
    currentpc = 64'h100; MemtoRegOut = VAL_A;
    cfg_we = 1'b1; cfg_idx = 1; cfg_pc = 64'h0; cfg_exp = 64'hDEAD;
    tick();
    cfg_we = 1'b0;
    chk("jump_pass1", pass_count, 1);
    chk("jump_done1", done, 0);
    MemtoRegOut = VAL_B; start = 1'b1;
    tick();
    start = 1'b0;
    chk("jump_pass2", pass_count, 2);
    chk("jump_done2", done, 1);
    chk("jump_fv", fail_valid, 0);
    chk("jump_all_passed", all_passed, 1);

    // Randomised runs against a run-level outcome model.
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < int'(NC); i++) begin
        thr[i] = 64'($urandom_range(0, 'h200));
        ex[i]  = {$urandom, $urandom};
        cfg_write(i, thr[i], ex[i]);
      end
      na = $urandom_range(0, 7);
      pc = 64'($urandom_range(0, 'h20));
      for (int t = 1; t <= int'(MAXT); t++) begin
        pc     = pc + 64'($urandom_range(0, 6));
        pcs[t] = pc;
        dat[t] = ($urandom_range(0, 2) != 0) ? ex[$urandom_range(0, NC - 1)] : {$urandom, $urandom};
      end
      n_eff = (na == 0) ? 1 : (na > NC ? NC : na);
      k = 0; mp = 0; mfv = 1'b0; mfi = 0; mfa = '0; end_t = 0; m_done = 1'b0;
      for (int t = 1; t <= int'(MAXT) && end_t == 0; t++) begin
        if (pcs[t] >= thr[k]) begin
          if (dat[t] == ex[k]) mp++;
          else if (!mfv) begin mfv = 1'b1; mfi = k; mfa = dat[t]; end
          if (k == n_eff - 1) begin m_done = 1'b1; end_t = t; end
          k++;
        end
        if (end_t == 0 && t == int'(MAXT)) end_t = t;
      end
      start_run(na);
      for (int t = 1; t <= int'(end_t); t++) begin
        currentpc = pcs[t]; MemtoRegOut = dat[t];
        tick();
        chk($sformatf("rnd%0d_busy_t%0d", r, t), busy, (t < int'(end_t)));
      end
      chk($sformatf("rnd%0d_done", r), done, m_done);
      chk($sformatf("rnd%0d_timeout", r), timeout, !m_done);
      chk($sformatf("rnd%0d_pass", r), pass_count, mp);
      chk($sformatf("rnd%0d_fv", r), fail_valid, mfv);
      chk($sformatf("rnd%0d_fidx", r), fail_idx, mfv ? mfi : 0);
      chk($sformatf("rnd%0d_factual", r), fail_actual, mfa);
      chk($sformatf("rnd%0d_all_passed", r), all_passed, m_done && (mp == n_eff));
    end

    // Async reset between edges mid-RUN, then a re-run on the cleared table.
    cfg_write(0, 64'h30, VAL_A);
    cfg_write(1, 64'h60, VAL_B);
    cfg_write(2, 64'h90, VAL_C);
    start_run(3);
    currentpc = 64'h40; MemtoRegOut = VAL_A;
    tick();
    currentpc = 64'h70; MemtoRegOut = 64'h5;
    tick();
    chk("midrst_pre_pass", pass_count, 1);
    chk("midrst_pre_fv", fail_valid, 1);
    @(negedge clk);
    #2 resetl = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_pass", pass_count, 0);
    chk("midrst_fv", fail_valid, 0);
    chk("midrst_fidx", fail_idx, 0);
    chk("midrst_factual", fail_actual, 0);
    repeat (2) @(negedge clk);
    resetl = 1'b1;
    tick();
    start_run(4);
    currentpc = '0; MemtoRegOut = '0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk($sformatf("rerun_pass_t%0d", t), pass_count, t);
      chk($sformatf("rerun_done_t%0d", t), done, (t == 4));
    end
    chk("rerun_all_passed", all_passed, 1);

`ifdef CHK_MASK_EN
    cfg_mask = 64'hFF;
    cfg_write(0, 64'h0, 64'h0000_0000_0000_00AB);
    cfg_mask = '1;
    start_run(1);
    currentpc = '0; MemtoRegOut = 64'hFF00_0000_0000_00AB;
    tick();
    chk("mask_done", done, 1);
    chk("mask_pass", pass_count, 1);
    chk("mask_fv", fail_valid, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_checkpoint_monitor.md
Name: proc_checkpoint_monitor

Overview:
Synthesizable, parametrised self-checking monitor for the single-cycle processor. It compares `MemtoRegOut` against a programmed table of (PC threshold, expected value) checkpoints and counts passes. A watchdog stops a run if the program never reaches its final checkpoint. It sits beside `singlecycle` in simulation or FPGA bring-up and observes `currentpc` and `MemtoRegOut` only.

Parameters:
- DATA_W, 64: width of the PC, observed data and expected values.
- NUM_CHECKS, 4: number of checkpoint table entries (≥1).
- IDX_W, $clog2(NUM_CHECKS) (min 1): checkpoint index width.
- WDOG_W, 16: watchdog counter width.
- WDOG_LIMIT, 16'h00FF: cycles in RUN before timeout (≥1, < 2^WDOG_W).

Ports:
- `CLK`, input, 1: single clock; all state updates on posedge.
- `resetl`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a run; pulse.
- `num_active`, input, IDX_W+1: checkpoints used this run (1..NUM_CHECKS); sampled on start.
- `cfg_we`, input, 1: table write strobe.
- `cfg_idx`, input, IDX_W: table entry to write.
- `cfg_pc`, input, DATA_W: PC threshold for the entry.
- `cfg_exp`, input, DATA_W: expected `MemtoRegOut` for the entry.
- `currentpc`, input, DATA_W: processor PC.
- `MemtoRegOut`, input, DATA_W: processor writeback value.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: all active checkpoints evaluated.
- `timeout`, output, 1: watchdog expired.
- `all_passed`, output, 1: `done` and pass_count == num_active.
- `pass_count`, output, IDX_W+1: checkpoints passed.
- `fail_valid`, output, 1: a mismatch has been recorded.
- `fail_idx`, output, IDX_W: index of the first failing checkpoint.
- `fail_actual`, output, DATA_W: observed value at the first failure.

Behaviour:
- Reset (async, `resetl`=0):
  - State = IDLE.
  - All outputs 0, including `fail_*`.
  - Table entries, checkpoint index and watchdog counter = 0.
- States: IDLE, RUN, DONE, TIMEOUT.
- IDLE:
  - `cfg_we` writes the table entry on the next posedge.
  - `cfg_idx` ≥ NUM_CHECKS is ignored.
  - `start` → RUN next cycle. On that edge: clear idx, pass_count, `fail_*` and watchdog; latch num_active, clamped to the range 1..NUM_CHECKS.
- RUN:
  - `cfg_we` is ignored.
  - Watchdog increments every cycle.
  - Each posedge, if currentpc ≥ table[idx].pc (unsigned): compare MemtoRegOut with table[idx].exp.
    - Equal: pass_count+1.
    - Not equal and `fail_valid`=0: set `fail_valid`, `fail_idx`=idx, `fail_actual`=MemtoRegOut. Later failures do not overwrite.
    - Then idx+1.
  - At most one checkpoint is evaluated per cycle, even if the PC satisfies several thresholds.
  - After evaluating idx == num_active-1 → DONE.
  - Watchdog reaching WDOG_LIMIT → TIMEOUT.
  - Simultaneous final checkpoint evaluation and watchdog hit: the checkpoint is evaluated and the state goes to DONE, not TIMEOUT.
- Output timing: `done`/`timeout`/`all_passed` are registered and assert the cycle after the deciding edge. They hold until the next `start` or reset.
- DONE/TIMEOUT:
  - Outputs hold.
  - `start` re-enters RUN with the clears above.
  - `cfg_we` is accepted, as in IDLE.
- Latency: a checkpoint condition true at posedge N shows in pass_count/`fail_*` after posedge N.
- Reset mid-RUN: immediate return to IDLE with all state cleared. The table is also cleared and must be reprogrammed.
- `start` while in RUN: ignored.

Optional Feature:
- Macro: `CHK_MASK_EN`.
- Defined:
  - Extra input port `cfg_mask` [DATA_W-1:0], written with each entry.
  - Comparison becomes ((MemtoRegOut ^ exp) & mask) == 0.
  - Mask resets to 0, which means don't-care on all bits.
- Undefined: port absent; full-width equality compare.

Decomposition:
- Package `proc_mon_pkg`:
  - State enum (IDLE/RUN/DONE/TIMEOUT).
  - Default DATA_W, NUM_CHECKS and WDOG_LIMIT constants.
  - Checkpoint entry struct {pc, exp[, mask]}.
- Sub-module `mon_watchdog`:
  - Clear and enable inputs; WDOG_W counter; `expired` output at WDOG_LIMIT.
  - Count saturates; no wrap.

Test Plan:
- Two-program pass: table {0x30→0xF, 0x60→0x123456789ABCDEF0}, num_active=2, stimulus PC stepping by 4 with matching data → `done`=1, pass_count=2, `all_passed`=1, `fail_valid`=0.
- Mismatch: entry1 observes 0x123456789ABCDEF1 → pass_count=1, `fail_valid`=1, `fail_idx`=1, `fail_actual`=0x123456789ABCDEF1, `all_passed`=0.
- Hang: PC stuck at 0x10, WDOG_LIMIT=0xFF → `timeout`=1 exactly 256 cycles after RUN entry, `done`=0.
- Tie: final threshold met on the same edge the watchdog hits its limit → DONE, `timeout`=0.
- Async reset asserted mid-RUN between clock edges → outputs 0 immediately. A re-run then needs the table rewritten; an unwritten table all-zero with expected 0 passes trivially.
- PC jumps past both thresholds in one cycle (0x0 → 0x100) → checkpoints evaluated on two consecutive edges, in order. With `CHK_MASK_EN` and mask 0xFF, a difference only in upper bits still passes.
